// File: rtl/cpu_types_pkg.sv
// Shared CPU pipeline types: register write source, operand forwarding
// source and the forwarding/hazard controller state encoding.
package cpu_types_pkg;

    typedef enum logic [1:0] {
        WRITE_ALU = 2'd0,
        WRITE_RAM = 2'd1,
        WRITE_NPC = 2'd2
    } wsrc_t;

    typedef enum logic [1:0] {
        FWD_REGFILE  = 2'd0,
        FWD_BYPASS   = 2'd1,
        FWD_CAPTURED = 2'd2
    } fwd_src_t;

    typedef enum logic [1:0] {
        RUN   = 2'd0,
        STALL = 2'd1,
        HOLD  = 2'd2
    } fwd_state_t;

endpackage

// File: rtl/fwd_hazard_unit_select.sv
// Per-operand bypass priority mux: the youngest post-execute stage writing the
// operand's source register supplies the value; otherwise the regfile value passes.
module fwd_select
    import cpu_types_pkg::*;
#(
    parameter int WORD_W = 32,
    parameter int REG_AW = 5,
    parameter int NSTAGE = 2
) (
    input  logic [NSTAGE*REG_AW-1:0] st_wsel,
    input  logic [NSTAGE*2-1:0]      st_wsrc,
    input  logic [NSTAGE*WORD_W-1:0] st_alu,
    input  logic [NSTAGE*WORD_W-1:0] st_npc,
    input  logic [NSTAGE*WORD_W-1:0] st_load,
    input  logic [NSTAGE-1:0]        st_load_vld,
    input  logic [REG_AW-1:0]        op_reg,
    input  logic                     op_use,
    input  logic [WORD_W-1:0]        op_val,
    output logic [WORD_W-1:0]        fwd_val,
    output logic                     fwd_hit,
    output logic                     not_ready
);

    always_comb begin
        fwd_val   = op_val;
        fwd_hit   = 1'b0;
        not_ready = 1'b0;
        // Walk oldest to youngest so the youngest match overwrites the rest.
        for (int i = NSTAGE - 1; i >= 0; i--) begin
            if (op_use && (op_reg != '0) && (st_wsel[i*REG_AW +: REG_AW] == op_reg)) begin
                fwd_hit = 1'b1;
                case (st_wsrc[i*2 +: 2])
                    WRITE_RAM: begin
                        fwd_val   = st_load[i*WORD_W +: WORD_W];
                        not_ready = ~st_load_vld[i];
                    end
                    WRITE_NPC: begin
                        fwd_val   = st_npc[i*WORD_W +: WORD_W];
                        not_ready = 1'b0;
                    end
                    default: begin
                        fwd_val   = st_alu[i*WORD_W +: WORD_W];
                        not_ready = 1'b0;
                    end
                endcase
            end
        end
    end

endmodule

// File: rtl/fwd_hazard_unit.sv
// Operand bypass network with load-use hazard detection, stall request and
// per-operand capture registers that hold bypassed values across downstream stalls.
module fwd_hazard_unit
    import cpu_types_pkg::*;
#(
    parameter int WORD_W = 32,
    parameter int REG_AW = 5,
    parameter int NSTAGE = 2,
    parameter int NOPS   = 3,
    parameter int CNT_W  = 16
) (
    input  logic                     CLK,
    input  logic                     RST,
    input  logic [NSTAGE*REG_AW-1:0] st_wsel,
    input  logic [NSTAGE*2-1:0]      st_wsrc,
    input  logic [NSTAGE*WORD_W-1:0] st_alu,
    input  logic [NSTAGE*WORD_W-1:0] st_npc,
    input  logic [NSTAGE*WORD_W-1:0] st_load,
    input  logic [NSTAGE-1:0]        st_load_vld,
    input  logic [REG_AW-1:0]        ex_wsel,
    input  logic                     ex_is_load,
    input  logic [NOPS*REG_AW-1:0]   op_reg,
    input  logic [NOPS-1:0]          op_use,
    input  logic [NOPS*WORD_W-1:0]   op_val,
    input  logic                     pipe_stall,
    input  logic                     dec_adv,
    input  logic                     flush,
    output logic [NOPS*WORD_W-1:0]   op_fwd,
    output logic [NOPS*2-1:0]        fwd_src,
    output logic                     hz_stall,
    output logic [CNT_W-1:0]         stall_cnt,
    output fwd_state_t               dbg_state
);

    // Handshake: upstream may move decode into execute (dec_adv) only in a cycle
    // where hz_stall is low; a hazard always overrides a concurrent dec_adv.

    fwd_state_t        state, state_nxt;
    logic [WORD_W-1:0] sel_val [NOPS];
    logic [NOPS-1:0]   sel_hit, sel_nr, op_hz;
    logic [WORD_W-1:0] cap     [NOPS];
    logic [NOPS-1:0]   cap_vld;
    logic              hazard, hold_hz, cap_load, cap_clr;

    for (genvar k = 0; k < NOPS; k++) begin : g_op
        fwd_select #(
            .WORD_W (WORD_W),
            .REG_AW (REG_AW),
            .NSTAGE (NSTAGE)
        ) u_sel (
            .st_wsel     (st_wsel),
            .st_wsrc     (st_wsrc),
            .st_alu      (st_alu),
            .st_npc      (st_npc),
            .st_load     (st_load),
            .st_load_vld (st_load_vld),
            .op_reg      (op_reg[k*REG_AW +: REG_AW]),
            .op_use      (op_use[k]),
            .op_val      (op_val[k*WORD_W +: WORD_W]),
            .fwd_val     (sel_val[k]),
            .fwd_hit     (sel_hit[k]),
            .not_ready   (sel_nr[k])
        );

        assign op_hz[k] = sel_nr[k] |
                          (ex_is_load && (ex_wsel != '0) && op_use[k] &&
                           (op_reg[k*REG_AW +: REG_AW] == ex_wsel));

        always_comb begin
            if ((state == HOLD) && cap_vld[k]) begin
                op_fwd[k*WORD_W +: WORD_W] = cap[k];
                fwd_src[k*2 +: 2]          = FWD_CAPTURED;
            end else begin
                op_fwd[k*WORD_W +: WORD_W] = sel_val[k];
                fwd_src[k*2 +: 2]          = sel_hit[k] ? FWD_BYPASS : FWD_REGFILE;
            end
        end
    end

    assign hazard    = |op_hz;
    assign hold_hz   = |(op_hz & ~cap_vld);
    assign dbg_state = state;

    always_comb begin
        state_nxt = state;
        hz_stall  = 1'b0;
        cap_load  = 1'b0;
        cap_clr   = 1'b0;
        case (state)
            RUN: begin
                hz_stall = hazard;
                if (hazard) begin
                    state_nxt = STALL;
                end else if (pipe_stall) begin
                    cap_load  = 1'b1;
                    state_nxt = HOLD;
                end
            end
            STALL: begin
                hz_stall = hazard;
                if (!hazard) state_nxt = RUN;
            end
            HOLD: begin
                // Captured operands are safe; only uncaptured ones can still stall.
                hz_stall = hold_hz;
                if (dec_adv && !hold_hz) begin
                    cap_clr   = 1'b1;
                    state_nxt = RUN;
                end
            end
            default: state_nxt = RUN;
        endcase
        if (flush) begin
            state_nxt = RUN;
            hz_stall  = 1'b0;
            cap_load  = 1'b0;
            cap_clr   = 1'b1;
        end
    end

    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            state     <= RUN;
            cap_vld   <= '0;
            stall_cnt <= '0;
            for (int k = 0; k < NOPS; k++) cap[k] <= '0;
        end else begin
            state <= state_nxt;
            if (hz_stall && (stall_cnt != '1)) stall_cnt <= stall_cnt + 1'b1;
            if (cap_clr) begin
                cap_vld <= '0;
            end else if (cap_load) begin
                cap_vld <= op_use;
                for (int k = 0; k < NOPS; k++) begin
                    if (op_use[k]) cap[k] <= sel_val[k];
                end
            end
        end
    end

endmodule
